// File: rtl/schedule_1.sv
// schedule_1: first scheduler stage.
// Picks one candidate lane per cycle (lowest accepted coprocessor, else the
// main core, else an illegal slot on lane 0), checks its sources against the
// destinations issued over the last HAZ_DEPTH advancing cycles, and registers
// either the instruction or a NOP bubble for the next stage.
module schedule_1 #(
  parameter int unsigned COP_NUMS  = 32'd1,
  parameter int unsigned PNUMS     = COP_NUMS + 1,
  parameter int unsigned HAZ_DEPTH = 32'd2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  STALL,
  input  logic                  MMU_WAIT,
  input  logic [PNUMS-1:0]      CHECK_ACCEPT,
  input  logic [32*PNUMS-1:0]   CHECK_PC,
  input  logic [17*PNUMS-1:0]   CHECK_OPCODE,
  input  logic [5*PNUMS-1:0]    CHECK_RD,
  input  logic [5*PNUMS-1:0]    CHECK_RS1,
  input  logic [5*PNUMS-1:0]    CHECK_RS2,
  input  logic [12*PNUMS-1:0]   CHECK_CSR,
  input  logic [32*PNUMS-1:0]   CHECK_IMM,
  output logic                  HAZARD,
  output logic                  SCHEDULE_VALID,
  output logic                  SCHEDULE_ILLEGAL,
  output logic [7:0]            SCHEDULE_PID,
  output logic [31:0]           SCHEDULE_PC,
  output logic [16:0]           SCHEDULE_OPCODE,
  output logic [4:0]            SCHEDULE_RD,
  output logic [4:0]            SCHEDULE_RS1,
  output logic [4:0]            SCHEDULE_RS2,
  output logic [11:0]           SCHEDULE_CSR,
  output logic [31:0]           SCHEDULE_IMM
);

  // addi x0, x0, 0 packed as {opcode7, funct3, funct7}
  localparam logic [16:0] NOP_OPCODE = {7'b0010011, 3'b000, 7'b0000000};

  logic        sel_illegal;
  logic [7:0]  sel_pid;
  logic [31:0] sel_pc;
  logic [16:0] sel_opcode;
  logic [4:0]  sel_rd;
  logic [4:0]  sel_rs1;
  logic [4:0]  sel_rs2;
  logic [11:0] sel_csr;
  logic [31:0] sel_imm;

  logic [HAZ_DEPTH-1:0] sb_valid;
  logic [4:0]           sb_rd [HAZ_DEPTH];

  logic hazard_hit;
  logic clear;
  logic hold;

  assign clear = RST || FLUSH;
  assign hold  = (STALL || MMU_WAIT) && !clear;

  // Lane select: default to lane 0, then let accepted coprocessor lanes
  // override in descending order so the lowest index ends up winning.
  always_comb begin
    sel_pid     = 8'd0;
    sel_illegal = !CHECK_ACCEPT[0];
    sel_pc      = CHECK_PC[31:0];
    sel_opcode  = CHECK_OPCODE[16:0];
    sel_rd      = CHECK_RD[4:0];
    sel_rs1     = CHECK_RS1[4:0];
    sel_rs2     = CHECK_RS2[4:0];
    sel_csr     = CHECK_CSR[11:0];
    sel_imm     = CHECK_IMM[31:0];
    for (int i = int'(PNUMS) - 1; i >= 1; i--) begin
      if (CHECK_ACCEPT[i]) begin
        sel_pid     = 8'(i);
        sel_illegal = 1'b0;
        sel_pc      = CHECK_PC[i*32 +: 32];
        sel_opcode  = CHECK_OPCODE[i*17 +: 17];
        sel_rd      = CHECK_RD[i*5 +: 5];
        sel_rs1     = CHECK_RS1[i*5 +: 5];
        sel_rs2     = CHECK_RS2[i*5 +: 5];
        sel_csr     = CHECK_CSR[i*12 +: 12];
        sel_imm     = CHECK_IMM[i*32 +: 32];
      end
    end
  end

  // RAW check of the selected sources against every live scoreboard entry;
  // x0 sources never match.
  always_comb begin
    hazard_hit = 1'b0;
    for (int k = 0; k < int'(HAZ_DEPTH); k++) begin
      if (sb_valid[k] &&
          (((sel_rs1 != 5'd0) && (sel_rs1 == sb_rd[k])) ||
           ((sel_rs2 != 5'd0) && (sel_rs2 == sb_rd[k])))) begin
        hazard_hit = 1'b1;
      end
    end
  end

  assign HAZARD = hazard_hit && !sel_illegal && !clear;

  // Scoreboard of recently issued destinations; only advances when the
  // stage advances, so stalled cycles do not age entries.
  always_ff @(posedge CLK) begin
    if (clear) begin
      sb_valid <= '0;
      for (int k = 0; k < int'(HAZ_DEPTH); k++) sb_rd[k] <= 5'd0;
    end else if (!hold) begin
      for (int k = int'(HAZ_DEPTH) - 1; k > 0; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_rd[k]    <= sb_rd[k-1];
      end
      sb_valid[0] <= !HAZARD && !sel_illegal && (sel_rd != 5'd0);
      sb_rd[0]    <= HAZARD ? 5'd0 : sel_rd;
    end
  end

  // Output register: bubble on reset/flush/hazard, hold on stall, else issue.
  always_ff @(posedge CLK) begin
    if (!hold) begin
      if (clear || HAZARD) begin
        SCHEDULE_VALID   <= 1'b0;
        SCHEDULE_ILLEGAL <= 1'b0;
        SCHEDULE_PID     <= 8'd0;
        SCHEDULE_PC      <= 32'd0;
        SCHEDULE_OPCODE  <= NOP_OPCODE;
        SCHEDULE_RD      <= 5'd0;
        SCHEDULE_RS1     <= 5'd0;
        SCHEDULE_RS2     <= 5'd0;
        SCHEDULE_CSR     <= 12'd0;
        SCHEDULE_IMM     <= 32'd0;
      end else begin
        SCHEDULE_VALID   <= 1'b1;
        SCHEDULE_ILLEGAL <= sel_illegal;
        SCHEDULE_PID     <= sel_pid;
        SCHEDULE_PC      <= sel_pc;
        SCHEDULE_OPCODE  <= sel_opcode;
        SCHEDULE_RD      <= sel_rd;
        SCHEDULE_RS1     <= sel_rs1;
        SCHEDULE_RS2     <= sel_rs2;
        SCHEDULE_CSR     <= sel_csr;
        SCHEDULE_IMM     <= sel_imm;
      end
    end
  end

endmodule
